muldiv_seq: RTL and testbench

Iterative sequencer for the RV32M multiply/divide instructions, placed beside the main ALU in the execute stage. The ALU handles single-cycle operations. This block accepts one M-extension operation per start, runs it over multiple cycles with a shift-add multiplier or a restoring divider, and reports completion with busy/done. The pipeline stalls on `busy` and writes back `result` when `done` pulses.

---
 rtl/muldiv_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// A shift-add multiplier and a restoring divider run on operand magnitudes,
// one bit per cycle. Signs are applied in a final FIX cycle. Divide-by-zero
// and signed overflow bypass the iteration and finish in two cycles.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request, sampled only when idle (IDLE or DONE)
//   kill    - synchronous abort of an operation in flight
//   funct3  - RV32M operation select (MUL..REMU)
//   rs1     - multiplicand / dividend
//   rs2     - multiplier / divisor
//   busy    - operation in progress (registered)
//   done    - one-cycle completion pulse (registered)
//   result  - final value, held until the next completion (registered)
module muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    prod_q, prod_d;     // {hi, lo}: product, or {remainder, quotient}
   logic [WIDTH-1:0] opb_q, opb_d;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0] spec_q, spec_d;     // precomputed special-case result
   logic             special_q, special_d;
   logic             wait_q, wait_d;     // special case spends one extra cycle in FIX
   logic             sign1_q, sign1_d;
   logic             sign2_q, sign2_d;
   logic [2:0]       op_q, op_d;
   logic             busy_d, done_d;
   logic [WIDTH-1:0] result_d;

   // Start-time operand decode
   logic             rs1_signed, rs2_signed;
   logic             neg1, neg2;
   logic [WIDTH-1:0] abs1, abs2;
   logic             div0, ovf;
   logic [WIDTH-1:0] spec_val;
   logic             accept;

   always_comb begin
      rs1_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
      rs2_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
      neg1       = rs1_signed & rs1[WIDTH-1];
      neg2       = rs2_signed & rs2[WIDTH-1];
      abs1       = neg1 ? (-rs1) : rs1;
      abs2       = neg2 ? (-rs2) : rs2;
      div0       = funct3[2] && (rs2 == '0);
      ovf        = funct3[2] && !funct3[0]
                   && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
      // funct3[1] selects REM/REMU over DIV/DIVU
      if (div0) begin
         spec_val = funct3[1] ? rs1 : '1;
      end else begin
         spec_val = funct3[1] ? '0 : rs1;
      end
      accept = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   // One iteration of each algorithm
   logic [WIDTH:0]   mul_sum;
   logic [PW-1:0]    mul_next;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] div_hi;
   logic [PW-1:0]    div_next;

   always_comb begin
      // Multiplier bit is prod_q[0]; partial sum is added to the high half, then shift right
      mul_sum   = prod_q[0] ? ({1'b0, prod_q[PW-1:WIDTH]} + {1'b0, opb_q})
                            : {1'b0, prod_q[PW-1:WIDTH]};
      mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
      // Partial remainder shifted left by one with the next dividend bit
      div_trial = prod_q[PW-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, opb_q};
      div_hi    = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
      div_next  = {div_hi, prod_q[WIDTH-2:0], ~div_diff[WIDTH]};
   end

   // Sign correction and result select
   logic [PW-1:0]    mul_res;
   logic [WIDTH-1:0] mul_sel;
   logic [WIDTH-1:0] quo, rem, div_sel;
   logic [WIDTH-1:0] fix_val;

   always_comb begin
      mul_res = (sign1_q ^ sign2_q) ? (-prod_q) : prod_q;
      mul_sel = (op_q[1:0] == 2'b00) ? mul_res[WIDTH-1:0] : mul_res[PW-1:WIDTH];
      quo     = prod_q[WIDTH-1:0];
      rem     = prod_q[PW-1:WIDTH];
      if (op_q[1]) begin
         div_sel = sign1_q ? (-rem) : rem;
      end else begin
         div_sel = (sign1_q ^ sign2_q) ? (-quo) : quo;
      end
      if (special_q) begin
         fix_val = spec_q;
      end else begin
         fix_val = op_q[2] ? div_sel : mul_sel;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      opb_d     = opb_q;
      spec_d    = spec_q;
      special_d = special_q;
      wait_d    = wait_q;
      sign1_d   = sign1_q;
      sign2_d   = sign2_q;
      op_d      = op_q;
      result_d  = result;

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               prod_d = op_q[2] ? div_next : mul_next;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = S_FIX;
                  cnt_d   = '0;
               end
            end
         end
         S_FIX: begin
            if (kill) begin
               state_d = S_IDLE;
               wait_d  = 1'b0;
            end else if (wait_q) begin
               wait_d = 1'b0;
            end else begin
               state_d  = S_DONE;
               result_d = fix_val;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Capture operands on an accepted start (only possible in IDLE or DONE)
      if (accept) begin
         op_d      = funct3;
         sign1_d   = neg1;
         sign2_d   = neg2;
         cnt_d     = '0;
         special_d = div0 | ovf;
         wait_d    = div0 | ovf;
         spec_d    = spec_val;
         if (funct3[2]) begin
            opb_d  = abs2;
            prod_d = {{WIDTH{1'b0}}, abs1};
         end else begin
            opb_d  = abs1;
            prod_d = {{WIDTH{1'b0}}, abs2};
         end
         state_d = (div0 | ovf) ? S_FIX : S_CALC;
      end

      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         prod_q    <= '0;
         opb_q     <= '0;
         spec_q    <= '0;
         special_q <= 1'b0;
         wait_q    <= 1'b0;
         sign1_q   <= 1'b0;
         sign2_q   <= 1'b0;
         op_q      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         opb_q     <= opb_d;
         spec_q    <= spec_d;
         special_q <= special_d;
         wait_q    <= wait_d;
         sign1_q   <= sign1_d;
         sign2_q   <= sign2_d;
         op_q      <= op_d;
         busy      <= busy_d;
         done      <= done_d;
         result    <= result_d;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (WIDTH=32).
module tb_muldiv_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for exactly one edge
   task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      funct3 = f;
      rs1    = a;
      rs2    = b;
      step();
      start  = 1'b0;
      rs1    = 32'h0;
      rs2    = 32'h0;
   endtask

   // Wait for done; pre = edges already elapsed since the accepting edge
   task automatic wait_done(input string tag, input logic [31:0] exp, input int lat_exp, input int pre);
      int lat   = pre;
      int nbusy = 0;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1) nbusy++;
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
      check({tag, "_busy_cycles"}, 32'(nbusy), 32'(lat_exp - pre));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_result"}, result, exp);
   endtask

   // One edge after done: pulse gone, result held
   task automatic idle_check(input string tag, input logic [31:0] exp);
      step();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, result, exp);
   endtask

   task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      drive_start(f, a, b);
      wait_done(tag, exp, lat, 0);
      idle_check(tag, exp);
   endtask

   // Watch for a stray done over a window
   task automatic no_done(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (done === 1'b1) seen++;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      kill   = 1'b0;
      funct3 = 3'b000;
      rs1    = 32'h0;
      rs2    = 32'h0;
      step();
      step();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'h0);
      rst = 1'b0;
      step();

      run("mul",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run("mulh",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      run("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run("div",    OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run("rem",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run("divu",   OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
      run("remu",   OP_REMU,   32'd100,      32'd7,        32'd2,        33);

      run("div_by0",  OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 2);
      run("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
      run("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        2);
      run("remu_by0", OP_REMU, 32'd5,        32'd0,        32'd5,        2);

      // Abort mid-CALC: busy drops, no done, result keeps 5
      drive_start(OP_DIVU, 32'd100, 32'd7);
      repeat (9) step();
      kill = 1'b1;
      step();
      kill = 1'b0;
      check("kill_busy", 32'(busy), 32'd0);
      check("kill_done", 32'(done), 32'd0);
      check("kill_result", result, 32'd5);
      no_done("kill_no_done", 40);
      run("after_kill", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

      // kill in IDLE suppresses a simultaneous start
      kill  = 1'b1;
      start = 1'b1;
      funct3 = OP_MUL;
      rs1   = 32'd2;
      rs2   = 32'd3;
      step();
      kill  = 1'b0;
      start = 1'b0;
      check("idle_kill_busy", 32'(busy), 32'd0);
      no_done("idle_kill_no_done", 40);

      // start pulsed mid-CALC with new operands is ignored
      drive_start(OP_MUL, 32'd7, 32'hFFFFFFFD);
      repeat (5) step();
      start  = 1'b1;
      funct3 = OP_DIVU;
      rs1    = 32'd100;
      rs2    = 32'd7;
      step();
      start  = 1'b0;
      wait_done("hold", 32'hFFFFFFEB, 33, 6);
      idle_check("hold", 32'hFFFFFFEB);

      // Back-to-back: new start in the done cycle
      drive_start(OP_DIVU, 32'd100, 32'd7);
      wait_done("b2b_first", 32'd14, 33, 0);
      drive_start(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("b2b_busy_rise", 32'(busy), 32'd1);
      wait_done("b2b_second", 32'hFFFFFFFE, 33, 0);
      idle_check("b2b_second", 32'hFFFFFFFE);

      // Reset mid-CALC
      drive_start(OP_MUL, 32'd7, 32'hFFFFFFFD);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'h0);
      no_done("rst_no_done", 40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
